tthbif_uart_regif: RTL
======================

Name: tthbif_uart_regif

Overview:
- UART-side command responder and register file for the tthbif lane block.
- Consumes bytes from the uart receive stream and executes single-byte-address read and write commands.
- Returns one response byte per command on the uart transmit handshake.
- Drives the tap-select and lane-enable controls that are currently tied to constants at the top level.

Parameters:
- TIMEOUT_CLKS, 1000000: clocks allowed between the command byte and the data byte of a write before the command is abandoned.
- ID_VALUE, 8'hB1: constant returned by the read-only ID register.
- TAPSEL_RST, 8'hFF: reset value of the TAPSEL register.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high. One clock; reset is synchronous and active-high.
- rx_data_valid_i  in  1  one-cycle strobe from uart rx: byte available.
- rx_data_i  in  8  received byte, valid with the strobe.
- tx_data_ready_i  in  1  uart tx can accept a byte.
- tx_data_valid_o  out  1  response byte valid.
- tx_data_o  out  8  response byte.
- rx_flop_tap_sel_o  out  2  TAPSEL[1:0].
- rx_comb_tap_sel_o  out  2  TAPSEL[3:2].
- tx_flop_tap_sel_o  out  2  TAPSEL[5:4].
- tx_comb_tap_sel_o  out  2  TAPSEL[7:6].
- lane_en_o  out  1  CTRL[0].
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset, while rst_i is high at a clock edge:
  - state=IDLE; tx_data_valid_o=0; tx_data_o=8'h00.
  - TAPSEL=TAPSEL_RST; CTRL[0]=1; SCRATCH=8'h00; timeout counter=0.
  - Applies mid-command and mid-response: a pending response is discarded and no register changes.
- Command byte format:
  - [7] wr: 1=write, 0=read.
  - [6:4] must be 3'b000.
  - [3:0] address.
- Register map:
  - 0x0 TAPSEL: rw.
  - 0x1 CTRL: rw, bit0 only. Reads return {7'b0,CTRL[0]}; writes to bits[7:1] are ignored.
  - 0x2 SCRATCH: rw.
  - 0x3 ID: ro, reads ID_VALUE.
  - 0x4-0xF: unmapped.
- Response codes: ACK=8'hAA, NAK=8'hEE.
- State machine, IDLE / DATA / RESP:
  - IDLE, byte with [6:4]!=0: load NAK and go to RESP. No data byte is consumed.
  - IDLE, read: load the register value (NAK if unmapped) and go to RESP.
  - IDLE, write: latch the address, clear the counter, go to DATA.
  - DATA, byte arrives: mapped rw address gets the register written and ACK loaded; ID or unmapped address gets NAK with no register change. Go to RESP either way.
  - DATA, no byte: counter increments each cycle. When the counter reaches TIMEOUT_CLKS-1 with no byte, go to IDLE with no response and no write.
  - RESP: tx_data_valid_o=1 with tx_data_o stable until a cycle where tx_data_ready_i=1. On that cycle the byte transfers, and next cycle tx_data_valid_o=0 and state=IDLE.
- Latency:
  - Byte accepted at edge N: tx_data_valid_o is high from N+1.
  - Write: the updated output pins are visible from N+1, the same cycle the ACK is offered.
  - If tx_data_ready_i is already high, the response transfers at edge N+1. A new command byte can then be accepted at N+2.
- Boundary cases:
  - rx_data_valid_i while in RESP: byte dropped, no state change. The host must wait for the response.
  - Byte arriving on the same edge the timeout expires: the byte wins and the write completes.
  - Back-to-back commands with no idle cycles are legal once the response has transferred.
  - Counter width is $clog2(TIMEOUT_CLKS)+1 and it never wraps.
  - The response byte is registered; tx_data_o holds its last value when valid is low.

Test Plan:
- Reset, then read 0x00, 0x01, 0x02, 0x03 -> responses FF, 01, 00, B1. Tap selects all 2'b11; lane_en_o=1.
- Write 0x80 then 0x1B -> ACK AA. Pins read 3,2,1,0 (rx_flop..tx_comb) from the cycle the ACK goes valid. Read 0x00 -> 1B.
- Write 0x83 then 0x55 -> NAK EE, ID unchanged. Read 0x05 -> EE. Command 0x10 -> EE immediately, and the next byte is parsed as a new command.
- TIMEOUT_CLKS=16: send 0x82 and wait 20 clocks -> no response, busy_o drops, SCRATCH unchanged. Then 0x82 followed by 0x3C within 10 clocks -> AA, and a read of 0x02 gives 3C.
- Hold tx_data_ready_i=0 for 50 cycles during a response while injecting an rx byte -> valid and data held stable, injected byte ignored. Release ready -> exactly one transfer.
- Assert rst_i while in DATA and while in RESP -> next cycle tx_data_valid_o=0, busy_o=0, registers at reset values.

Source files
------------

// File: rtl/tthbif_uart_regif.sv
// UART-side command responder and control register file for the tthbif lane block.
// It executes single-byte read and write commands and returns one response byte per command.
module tthbif_uart_regif #(
  parameter int          TIMEOUT_CLKS = 1000000,
  parameter logic [7:0]  ID_VALUE     = 8'hB1,
  parameter logic [7:0]  TAPSEL_RST   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_data_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       tx_data_ready_i,
  output logic       tx_data_valid_o,
  output logic [7:0] tx_data_o,
  output logic [1:0] rx_flop_tap_sel_o,
  output logic [1:0] rx_comb_tap_sel_o,
  output logic [1:0] tx_flop_tap_sel_o,
  output logic [1:0] tx_comb_tap_sel_o,
  output logic       lane_en_o,
  output logic       busy_o
);

  localparam int            CW       = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    ACK      = 8'hAA;
  localparam logic [7:0]    NAK      = 8'hEE;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    tapsel_reg, tapsel_next;
  logic          ctrl_reg, ctrl_next;
  logic [7:0]    scratch_reg, scratch_next;
  logic [3:0]    addr_reg, addr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic [7:0]    rd_value;

  // Read data is decoded straight from the incoming command byte.
  always_comb begin
    rd_value = NAK;
    case (rx_data_i[3:0])
      4'h0:    rd_value = tapsel_reg;
      4'h1:    rd_value = {7'b0, ctrl_reg};
      4'h2:    rd_value = scratch_reg;
      4'h3:    rd_value = ID_VALUE;
      default: rd_value = NAK;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    tapsel_next  = tapsel_reg;
    ctrl_next    = ctrl_reg;
    scratch_next = scratch_reg;
    addr_next    = addr_reg;
    cnt_next     = cnt_reg;
    tx_data_next = tx_data_reg;
    case (state_reg)
      IDLE: begin
        if (rx_data_valid_i) begin
          if (rx_data_i[6:4] != 3'b000) begin
            tx_data_next = NAK;
            state_next   = RESP;
          end else if (rx_data_i[7]) begin
            addr_next  = rx_data_i[3:0];
            cnt_next   = '0;
            state_next = DATA;
          end else begin
            tx_data_next = rd_value;
            state_next   = RESP;
          end
        end
      end
      DATA: begin
        // A data byte beats a timeout expiring on the same edge.
        if (rx_data_valid_i) begin
          state_next   = RESP;
          tx_data_next = ACK;
          case (addr_reg)
            4'h0:    tapsel_next  = rx_data_i;
            4'h1:    ctrl_next    = rx_data_i[0];
            4'h2:    scratch_next = rx_data_i;
            default: tx_data_next = NAK;
          endcase
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        if (tx_data_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      tapsel_reg  <= TAPSEL_RST;
      ctrl_reg    <= 1'b1;
      scratch_reg <= 8'h00;
      addr_reg    <= 4'h0;
      cnt_reg     <= '0;
      tx_data_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      tapsel_reg  <= tapsel_next;
      ctrl_reg    <= ctrl_next;
      scratch_reg <= scratch_next;
      addr_reg    <= addr_next;
      cnt_reg     <= cnt_next;
      tx_data_reg <= tx_data_next;
    end
  end

  assign tx_data_valid_o   = (state_reg == RESP);
  assign tx_data_o         = tx_data_reg;
  assign busy_o            = (state_reg != IDLE);
  assign rx_flop_tap_sel_o = tapsel_reg[1:0];
  assign rx_comb_tap_sel_o = tapsel_reg[3:2];
  assign tx_flop_tap_sel_o = tapsel_reg[5:4];
  assign tx_comb_tap_sel_o = tapsel_reg[7:6];
  assign lane_en_o         = ctrl_reg;

endmodule
